// File: rtl/tone_player.sv
// Square-wave note generator: programmable half-period and duration in ms,
// one note at a time via a start/busy/done handshake, with rest and abort.
module tone_player #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 18,
    parameter int DUR_W  = 12
) (
    input  logic             clk_100MHz,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [DUR_W-1:0] i_dur_ms,
    input  logic             i_rest,
    input  logic             i_stop,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tone
);
    localparam int MS_DIV = CLK_HZ / 1000;
    localparam int PRE_W  = $clog2(MS_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t           state;
    logic [CNT_W-1:0] hp_q;
    logic [CNT_W-1:0] tone_cnt;
    logic [DUR_W-1:0] rem_ms;
    logic [PRE_W-1:0] pre_cnt;
    logic             rest_q;
    logic             ms_tick;
    logic             last_ms;

    assign ms_tick = (pre_cnt == PRE_MAX);
    assign last_ms = (rem_ms == DUR_W'(1));

    always_ff @(posedge clk_100MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            hp_q     <= '0;
            tone_cnt <= '0;
            rem_ms   <= '0;
            pre_cnt  <= '0;
            rest_q   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_tone   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        hp_q     <= i_half_period;
                        rest_q   <= i_rest;
                        rem_ms   <= i_dur_ms;
                        tone_cnt <= '0;
                        pre_cnt  <= '0;
                        o_tone   <= 1'b0;
                        // A zero-length note completes immediately without going busy
                        if (i_dur_ms != '0) begin
                            state  <= PLAY;
                            o_busy <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_tone <= 1'b0;
                    end else if (ms_tick && last_ms) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_tone <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        // Compare before increment so hp = 2^CNT_W-1 never overflows
                        if (tone_cnt == hp_q) begin
                            tone_cnt <= '0;
                            if (!rest_q)
                                o_tone <= ~o_tone;
                        end else begin
                            tone_cnt <= tone_cnt + CNT_W'(1);
                        end
                        if (ms_tick) begin
                            pre_cnt <= '0;
                            rem_ms  <= rem_ms - DUR_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player: per-cycle expected {busy,done,tone}
// are queued when a note is launched and compared on each falling edge.
module tb_tone_player;
    localparam int CNT_W  = 18;
    localparam int DUR_W  = 12;
    localparam int MS_DIV = 10;

    logic             clk_100MHz = 1'b0;
    logic             i_rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_half_period;
    logic [DUR_W-1:0] i_dur_ms;
    logic             i_rest;
    logic             i_stop;
    logic             o_busy;
    logic             o_done;
    logic             o_tone;

    int errs   = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    tone_player #(.CLK_HZ(10_000), .CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
        .clk_100MHz   (clk_100MHz),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_half_period(i_half_period),
        .i_dur_ms     (i_dur_ms),
        .i_rest       (i_rest),
        .i_stop       (i_stop),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_tone       (o_tone)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare {busy,done,tone} each falling edge while expectations are pending
    always @(negedge clk_100MHz) begin
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            chk("bdt", {29'b0, o_busy, o_done, o_tone}, {29'b0, e});
        end
    end

    // Expected trace: one idle cycle before the accepting edge, nbusy busy
    // cycles, then tail (0 none, 1 done pulse, 2 idle without done).
    task automatic push_note(input int hp, input int dur, input bit rest,
                             input int nbusy, input int tail);
        exp_q.push_back(3'b000);
        if (dur == 0) begin
            exp_q.push_back(3'b010);
        end else begin
            for (int c = 0; c < nbusy; c++)
                exp_q.push_back({1'b1, 1'b0, rest ? 1'b0 : 1'(((c / (hp + 1)) % 2))});
            if (tail == 1) exp_q.push_back(3'b010);
            if (tail == 2) exp_q.push_back(3'b000);
        end
    endtask

    // Present a note for exactly one edge, then scramble the data inputs
    task automatic drive_note(input int hp, input int dur, input bit rest,
                              input int nbusy, input int tail);
        @(posedge clk_100MHz); #1;
        i_start       = 1'b1;
        i_half_period = CNT_W'(hp);
        i_dur_ms      = DUR_W'(dur);
        i_rest        = rest;
        push_note(hp, dur, rest, nbusy, tail);
        @(posedge clk_100MHz); #1;
        i_start       = 1'b0;
        i_half_period = CNT_W'($urandom);
        i_dur_ms      = DUR_W'($urandom);
        i_rest        = 1'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk_100MHz);
            t++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic push_idle(input int n);
        @(posedge clk_100MHz); #1;
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
        wait_drain();
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_half_period = '0;
        i_dur_ms = '0; i_rest = 1'b0; i_stop = 1'b0;
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_tone", o_tone, 0);
        @(negedge clk_100MHz) i_rst_n = 1'b1;

        // Normal note: 20 busy cycles, 2.5 periods of hp+1=4
        drive_note(3, 2, 0, 20, 1);
        wait_drain();
        push_idle(3);

        // Zero duration: done pulse only
        drive_note(5, 0, 0, 0, 1);
        wait_drain();
        push_idle(4);

        // Rest: busy 10 cycles, tone silent
        drive_note(1, 1, 1, 10, 1);
        wait_drain();

        // Abort on the 5th busy cycle: no done
        drive_note(3, 2, 0, 5, 2);
        repeat (4) @(posedge clk_100MHz);
        #1 i_stop = 1'b1;
        @(posedge clk_100MHz);
        #1 i_stop = 1'b0;
        wait_drain();
        push_idle(3);

        // Start pulse while playing must not retrigger
        drive_note(2, 1, 0, 10, 1);
        repeat (3) @(posedge clk_100MHz);
        #1 i_start = 1'b1;
        @(posedge clk_100MHz);
        #1 i_start = 1'b0;
        wait_drain();

        // Stop while idle does nothing
        @(posedge clk_100MHz); #1;
        i_stop = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(3'b000);
        repeat (3) @(posedge clk_100MHz);
        #1 i_stop = 1'b0;
        wait_drain();

        // Back-to-back with start held high: the done cycle accepts the next note
        @(posedge clk_100MHz); #1;
        i_start = 1'b1; i_half_period = '0; i_dur_ms = DUR_W'(1); i_rest = 1'b0;
        exp_q.push_back(3'b000);
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < MS_DIV; c++) exp_q.push_back({2'b10, 1'(c % 2)});
            exp_q.push_back(3'b010);
        end
        repeat (12) @(posedge clk_100MHz);
        #1 i_start = 1'b0;
        wait_drain();
        push_idle(3);

        // Long note, max-range half-period: tone stays low for the whole note
        drive_note((1 << CNT_W) - 1, 3, 0, 30, 1);
        wait_drain();

        // Asynchronous reset mid-note, then no done afterwards
        drive_note(3, 2, 0, 7, 0);
        wait_drain();
        @(negedge clk_100MHz);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_tone", o_tone, 0);
        @(negedge clk_100MHz) i_rst_n = 1'b1;
        push_idle(25);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
